alu_share_arb: RTL

- Two-requester arbiter and sequencer that shares one RV32I integer ALU instance (opcode encoding per core ALU: ADD 0000, SUB 1000, AND 0111, OR 0110, XOR 0100, SLT 0010, SLTU 0011, SLL 0001, SRL 0101, SRA 1101).
- Sits in the EXE region between two operand producers and a single registered result port. Example producers: main pipeline issue (req0) and address/branch-target helper (req1).
- Round-robin grant, valid/ready handshakes on both sides, one-cycle registered latency, full throughput of 1 op/cycle.

---
 rtl/alu_share_arb.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin arbiter that shares one RV32I integer ALU
// between two operand producers and one registered result port.
//
// Ports:
//   clk, rst_n            clock (rising edge) and async active-low reset
//   reqN_valid/ready      request handshake for requester N (N = 0, 1)
//   reqN_opc              4-bit core ALU opcode
//   reqN_sel_pc           ADD only: first operand is pc instead of reg1
//   reqN_pc/reg1/src2     32-bit operands
//   reqN_tag              opaque tag returned with the result
//   rsp_valid/ready       result handshake
//   rsp_id                index of the requester that issued the result
//   rsp_tag, rsp_result   tag and 32-bit ALU result
//
// One-cycle registered latency, one op per cycle. rsp_* come straight from
// flops; only reqN_ready depends combinationally on rsp_ready.
module alu_share_arb #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_opc,
  input  logic             req0_sel_pc,
  input  logic [31:0]      req0_pc,
  input  logic [31:0]      req0_reg1,
  input  logic [31:0]      req0_src2,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_opc,
  input  logic             req1_sel_pc,
  input  logic [31:0]      req1_pc,
  input  logic [31:0]      req1_reg1,
  input  logic [31:0]      req1_src2,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [31:0]      rsp_result
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;

  function automatic logic [31:0] alu(input logic [3:0]  opc,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
    logic [31:0] r;
    r = '0;
    case (opc)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLT:  r = {31'd0, $signed(a) < $signed(b)};
      OP_SLTU: r = {31'd0, a < b};
      OP_SLL:  r = a << b[4:0];
      OP_SRL:  r = a >> b[4:0];
      OP_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
      default: r = '0;  // undefined opcodes still complete, with result 0
    endcase
    return r;
  endfunction

  logic             rr;         // requester preferred when both are valid
  logic             grant;
  logic             can_issue;
  logic             accept;
  logic [3:0]       sel_opc;
  logic             sel_pc;
  logic [31:0]      sel_pcv;
  logic [31:0]      sel_reg1;
  logic [31:0]      sel_src2;
  logic [TAG_W-1:0] sel_tag;
  logic [31:0]      op_a;

  // Gating with rst_n keeps both readies low while reset is held, even
  // though the empty result slot would otherwise allow an issue.
  assign can_issue = rst_n & (~rsp_valid | rsp_ready);

  // A lone valid requester wins regardless of rr.
  assign grant      = (req0_valid & req1_valid) ? rr : req1_valid;
  assign req0_ready = can_issue & ~grant & req0_valid;
  assign req1_ready = can_issue &  grant & req1_valid;
  assign accept     = req0_ready | req1_ready;

  always_comb begin
    // NOTE: every output gets a default before the mux, so no latch is inferred.
    sel_opc  = req0_opc;
    sel_pc   = req0_sel_pc;
    sel_pcv  = req0_pc;
    sel_reg1 = req0_reg1;
    sel_src2 = req0_src2;
    sel_tag  = req0_tag;
    if (grant) begin
      sel_opc  = req1_opc;
      sel_pc   = req1_sel_pc;
      sel_pcv  = req1_pc;
      sel_reg1 = req1_reg1;
      sel_src2 = req1_src2;
      sel_tag  = req1_tag;
    end
  end

  // pc is only ever an operand of ADD; other opcodes ignore sel_pc.
  assign op_a = (sel_opc == OP_ADD && sel_pc) ? sel_pcv : sel_reg1;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_tag    <= '0;
      rsp_result <= '0;
      rr         <= 1'b0;
    end else if (accept) begin
      // Covers accept-while-draining too: the slot refills without a bubble.
      rsp_valid  <= 1'b1;
      rsp_id     <= grant;
      rsp_tag    <= sel_tag;
      rsp_result <= alu(sel_opc, op_a, sel_src2);
      rr         <= ~grant;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

endmodule
